// File: rtl/fma_special_case_scheduler.sv
// fma_special_case_scheduler
// Issue controller in front of a fixed-latency single-precision FMA (A*B+C).
// Operands are classified (zero / Inf / NaN / denormal). Special cases are
// resolved here and their result travels in a tag delay line that runs in
// lock-step with the FMA pipeline. Results retire strictly in issue order, and
// output backpressure freezes the tag line and the FMA together.
// Build option: define FMA_SCHED_DAZ_EN to treat denormal operands as signed
// zeros, both for classification and on the operands forwarded to the FMA.
module fma_special_case_scheduler #(
  parameter int PARM_XLEN = 32,
  parameter int PARM_EXP  = 8,
  parameter int PARM_MANT = 23,
  parameter int PARM_LAT  = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [PARM_XLEN-1:0] A_i,
  input  logic [PARM_XLEN-1:0] B_i,
  input  logic [PARM_XLEN-1:0] C_i,
  output logic                 mac_en_o,
  output logic                 mac_valid_o,
  output logic [PARM_XLEN-1:0] mac_a_o,
  output logic [PARM_XLEN-1:0] mac_b_o,
  output logic [PARM_XLEN-1:0] mac_c_o,
  input  logic [PARM_XLEN-1:0] mac_result_i,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic [PARM_XLEN-1:0] res_o,
  output logic                 res_invalid_o,
  output logic                 res_bypass_o,
  output logic [3:0]           inflight_o
);

  localparam int OP_A = 0;
  localparam int OP_B = 1;
  localparam int OP_C = 2;
  localparam int MSB  = PARM_XLEN - 1;
  localparam int LAST = PARM_LAT - 1;

  // Canonical quiet NaN returned for every NaN-producing special case.
  localparam logic [PARM_XLEN-1:0] QNAN =
    {1'b0, {PARM_EXP{1'b1}}, 1'b1, {(PARM_MANT-1){1'b0}}};

  // ---------------------------------------------------------------------------
  // Operand classification (index 0 = A, 1 = B, 2 = C)
  // ---------------------------------------------------------------------------
  logic [2:0][PARM_XLEN-1:0] op_raw;
  logic [2:0][PARM_XLEN-1:0] op_eff;
  logic [2:0]                is_zero;
  logic [2:0]                is_inf;
  logic [2:0]                is_nan;
  logic [2:0]                is_snan;

  assign op_raw = {C_i, B_i, A_i};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cls
      logic exp_zero;
      logic exp_full;
      logic mant_zero;

      assign exp_zero  = (op_raw[gi][PARM_MANT +: PARM_EXP] == '0);
      assign exp_full  = &op_raw[gi][PARM_MANT +: PARM_EXP];
      assign mant_zero = (op_raw[gi][PARM_MANT-1:0] == '0);

      assign is_inf[gi]  = exp_full & mant_zero;
      assign is_nan[gi]  = exp_full & ~mant_zero;
      // A NaN with the quiet bit clear is signalling.
      assign is_snan[gi] = is_nan[gi] & ~op_raw[gi][PARM_MANT-1];

`ifdef FMA_SCHED_DAZ_EN
      // Denormals collapse onto zero of the same sign.
      assign is_zero[gi] = exp_zero;
      assign op_eff[gi]  = exp_zero ? {op_raw[gi][MSB], {(PARM_XLEN-1){1'b0}}}
                                    : op_raw[gi];
`else
      // Denormals are ordinary finite numbers for the arithmetic path.
      assign is_zero[gi] = exp_zero & mant_zero;
      assign op_eff[gi]  = op_raw[gi];
`endif
    end
  endgenerate

  assign mac_a_o = op_eff[OP_A];
  assign mac_b_o = op_eff[OP_B];
  assign mac_c_o = op_eff[OP_C];

  // ---------------------------------------------------------------------------
  // Special-case resolution
  // ---------------------------------------------------------------------------
  logic                 prod_sign;
  logic                 prod_inf;
  logic                 prod_zero;
  logic                 sc_bypass;
  logic                 sc_invalid;
  logic [PARM_XLEN-1:0] sc_result;

  assign prod_sign = op_eff[OP_A][MSB] ^ op_eff[OP_B][MSB];
  assign prod_inf  = is_inf[OP_A] | is_inf[OP_B];
  assign prod_zero = is_zero[OP_A] | is_zero[OP_B];

  // Priority chain: the first matching special case decides the result.
  always_comb begin
    sc_bypass  = 1'b1;
    sc_invalid = 1'b0;
    sc_result  = '0;
    if (|is_nan) begin
      sc_result  = QNAN;
      sc_invalid = |is_snan;
    end else if ((is_inf[OP_A] & is_zero[OP_B]) | (is_zero[OP_A] & is_inf[OP_B])) begin
      sc_result  = QNAN;
      sc_invalid = 1'b1;
    end else if (prod_inf & is_inf[OP_C] & (prod_sign != op_eff[OP_C][MSB])) begin
      sc_result  = QNAN;
      sc_invalid = 1'b1;
    end else if (prod_inf) begin
      sc_result = {prod_sign, {PARM_EXP{1'b1}}, {PARM_MANT{1'b0}}};
    end else if (is_inf[OP_C]) begin
      sc_result = op_eff[OP_C];
    end else if (prod_zero & is_zero[OP_C]) begin
      sc_result = {prod_sign & op_eff[OP_C][MSB], {(PARM_XLEN-1){1'b0}}};
    end else if (prod_zero) begin
      sc_result = op_eff[OP_C];
    end else begin
      sc_bypass = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Handshake and pipeline advance
  // ---------------------------------------------------------------------------
  logic [PARM_LAT-1:0]  tag_valid_reg;
  logic [PARM_LAT-1:0]  tag_bypass_reg;
  logic [PARM_LAT-1:0]  tag_invalid_reg;
  logic [PARM_XLEN-1:0] tag_result_reg [PARM_LAT];
  logic                 stall;
  logic                 accept;

  // A result that cannot leave freezes the whole pipeline, FMA included.
  assign stall       = tag_valid_reg[LAST] & ~res_ready_i;
  assign mac_en_o    = ~stall & ~rst_i;
  assign req_ready_o = ~stall & ~rst_i;
  assign accept      = req_valid_i & req_ready_o;
  // Bypassed ops hold a tag slot to preserve ordering but skip the FMA.
  assign mac_valid_o = accept & ~sc_bypass;

  // Tag delay line: stage 0 captures the accepted op (or a bubble), all
  // stages shift together whenever the FMA advances.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tag_valid_reg   <= '0;
      tag_bypass_reg  <= '0;
      tag_invalid_reg <= '0;
      for (int i = 0; i < PARM_LAT; i++) begin
        tag_result_reg[i] <= '0;
      end
    end else if (mac_en_o) begin
      for (int i = PARM_LAT - 1; i > 0; i--) begin
        tag_valid_reg[i]   <= tag_valid_reg[i-1];
        tag_bypass_reg[i]  <= tag_bypass_reg[i-1];
        tag_invalid_reg[i] <= tag_invalid_reg[i-1];
        tag_result_reg[i]  <= tag_result_reg[i-1];
      end
      tag_valid_reg[0]   <= accept;
      tag_bypass_reg[0]  <= accept & sc_bypass;
      tag_invalid_reg[0] <= accept & sc_bypass & sc_invalid;
      tag_result_reg[0]  <= (accept & sc_bypass) ? sc_result : '0;
    end
  end

  // Occupancy: number of valid tag stages.
  always_comb begin
    inflight_o = '0;
    for (int i = 0; i < PARM_LAT; i++) begin
      inflight_o = inflight_o + {3'b000, tag_valid_reg[i]};
    end
  end

  // ---------------------------------------------------------------------------
  // Result port: the last tag stage selects between FMA and stored result.
  // Bubble and reset stages hold a zero result, so res_o reads 0 when idle.
  // ---------------------------------------------------------------------------
  assign res_valid_o   = tag_valid_reg[LAST];
  assign res_bypass_o  = tag_bypass_reg[LAST];
  assign res_invalid_o = tag_invalid_reg[LAST];
  assign res_o         = (tag_valid_reg[LAST] & ~tag_bypass_reg[LAST]) ? mac_result_i
                                                                       : tag_result_reg[LAST];

endmodule

// File: tb/tb_fma_special_case_scheduler.sv
// Self-checking bench for fma_special_case_scheduler (PARM_LAT = 3).
// A stand-in FMA pipeline with the same depth produces arithmetic results;
// expected values come from constants and a rule-level reference model.
`timescale 1ns/1ps
module tb_fma_special_case_scheduler;

  localparam int          LAT  = 3;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam logic [31:0] PA   = 32'h3F800000;
  localparam logic [31:0] PB   = 32'h40000000;
  localparam logic [31:0] PC   = 32'h40400000;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [31:0] A_i = '0;
  logic [31:0] B_i = '0;
  logic [31:0] C_i = '0;
  logic        mac_en_o;
  logic        mac_valid_o;
  logic [31:0] mac_a_o;
  logic [31:0] mac_b_o;
  logic [31:0] mac_c_o;
  logic [31:0] mac_result_i;
  logic        res_valid_o;
  logic        res_ready_i = 1'b1;
  logic [31:0] res_o;
  logic        res_invalid_o;
  logic        res_bypass_o;
  logic [3:0]  inflight_o;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] res;
    logic        inv;
    logic        byp;
  } exp_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [31:0] res;
    logic        inv;
    logic        byp;
  } case_t;

  fma_special_case_scheduler #(
    .PARM_XLEN(32), .PARM_EXP(8), .PARM_MANT(23), .PARM_LAT(LAT)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .A_i(A_i), .B_i(B_i), .C_i(C_i),
    .mac_en_o(mac_en_o), .mac_valid_o(mac_valid_o),
    .mac_a_o(mac_a_o), .mac_b_o(mac_b_o), .mac_c_o(mac_c_o),
    .mac_result_i(mac_result_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_o(res_o),
    .res_invalid_o(res_invalid_o), .res_bypass_o(res_bypass_o),
    .inflight_o(inflight_o)
  );

  always #5 clk_i = ~clk_i;

  // Stand-in arithmetic: the test-plan triple returns 5.0, anything else a hash.
  function automatic logic [31:0] fma_mock(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c);
    if (a == PA && b == PB && c == PC) return 32'h40A00000;
    return {a[15:0] ^ c[31:16], b[15:0] + c[15:0]} ^ 32'h5A5A0F0F;
  endfunction

  // Stand-in FMA pipeline: advances only on mac_en_o, garbage for bubbles.
  logic [31:0] fma_pipe [LAT];
  always @(posedge clk_i) begin
    if (mac_en_o) begin
      for (int i = LAT - 1; i > 0; i--) fma_pipe[i] <= fma_pipe[i-1];
      fma_pipe[0] <= mac_valid_o ? fma_mock(mac_a_o, mac_b_o, mac_c_o) : $urandom;
    end
  end
  assign mac_result_i = fma_pipe[LAT-1];

  // ---------------- reference model (IEEE special-case rules) ----------------
  function automatic bit f_zero(input logic [31:0] x);
`ifdef FMA_SCHED_DAZ_EN
    return x[30:23] == 8'h00;
`else
    return x[30:0] == 31'h0;
`endif
  endfunction
  function automatic bit f_inf(input logic [31:0] x);
    return x[30:0] == 31'h7F800000;
  endfunction
  function automatic bit f_nan(input logic [31:0] x);
    return x[30:23] == 8'hFF && x[22:0] != 23'h0;
  endfunction
  function automatic bit f_snan(input logic [31:0] x);
    return f_nan(x) && !x[22];
  endfunction
  function automatic logic [31:0] f_flush(input logic [31:0] x);
`ifdef FMA_SCHED_DAZ_EN
    if (x[30:23] == 8'h00) return {x[31], 31'h0};
`endif
    return x;
  endfunction

  function automatic exp_t ref_op(input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] c);
    exp_t e;
    bit   ps, pinf, pz;
    ps   = a[31] ^ b[31];
    pinf = f_inf(a) || f_inf(b);
    pz   = f_zero(a) || f_zero(b);
    e.byp = 1'b1;
    e.inv = 1'b0;
    e.res = '0;
    if (f_nan(a) || f_nan(b) || f_nan(c)) begin
      e.res = QNAN;
      e.inv = f_snan(a) || f_snan(b) || f_snan(c);
    end else if (pinf && pz) begin
      e.res = QNAN; e.inv = 1'b1;
    end else if (pinf && f_inf(c) && ps != c[31]) begin
      e.res = QNAN; e.inv = 1'b1;
    end else if (pinf) begin
      e.res = {ps, 8'hFF, 23'h0};
    end else if (f_inf(c)) begin
      e.res = c;
    end else if (pz && f_zero(c)) begin
      e.res = {ps & c[31], 31'h0};
    end else if (pz) begin
      e.res = f_flush(c);
    end else begin
      e.byp = 1'b0;
      e.res = fma_mock(f_flush(a), f_flush(b), f_flush(c));
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_normal();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
  endfunction

  function automatic logic [31:0] rand_op();
    logic s;
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 7))
      0:       return {s, 31'h0};
      1:       return {s, 8'hFF, 23'h0};
      2:       return {s, 8'hFF, 1'b1, 22'($urandom)};
      3:       return {s, 8'hFF, 1'b0, 21'($urandom), 1'b1};
      4:       return {s, 8'h00, 22'($urandom), 1'b1};
      default: return rand_normal();
    endcase
  endfunction

  // One clock cycle: drive just after the rising edge, return at the falling edge.
  task automatic tick(input logic rst, input logic v, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] c, input logic rdy);
    @(posedge clk_i);
    #1;
    rst_i = rst; req_valid_i = v; A_i = a; B_i = b; C_i = c; res_ready_i = rdy;
    @(negedge clk_i);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    tick(1, 1, PA, PB, PC, 1);
    tick(1, 1, PA, PB, PC, 1);
    total++; if (res_valid_o !== 1'b0) begin bad++; $display("FAIL reset_res_valid got=%b exp=0", res_valid_o); end
    total++; if (inflight_o !== 4'd0) begin bad++; $display("FAIL reset_inflight got=%0d exp=0", inflight_o); end
    total++; if (res_o !== 32'h0) begin bad++; $display("FAIL reset_res got=%h exp=00000000", res_o); end
    total++; if (res_invalid_o !== 1'b0) begin bad++; $display("FAIL reset_invalid got=%b exp=0", res_invalid_o); end
    total++; if (res_bypass_o !== 1'b0) begin bad++; $display("FAIL reset_bypass got=%b exp=0", res_bypass_o); end
    total++; if (mac_en_o !== 1'b0) begin bad++; $display("FAIL reset_mac_en got=%b exp=0", mac_en_o); end
    total++; if (mac_valid_o !== 1'b0) begin bad++; $display("FAIL reset_mac_valid got=%b exp=0", mac_valid_o); end
    total++; if (req_ready_o !== 1'b0) begin bad++; $display("FAIL reset_req_ready got=%b exp=0", req_ready_o); end
    tick(0, 0, 0, 0, 0, 1);
    total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL idle_req_ready got=%b exp=1", req_ready_o); end
    total++; if (mac_en_o !== 1'b1) begin bad++; $display("FAIL idle_mac_en got=%b exp=1", mac_en_o); end
    $display("reset: checks done");
  endtask

  task automatic test_latency();
    tick(0, 1, PA, PB, PC, 1);
    total++; if (mac_valid_o !== 1'b1) begin bad++; $display("FAIL lat_mac_valid got=%b exp=1", mac_valid_o); end
    total++; if (req_ready_o !== 1'b1) begin bad++; $display("FAIL lat_req_ready got=%b exp=1", req_ready_o); end
    for (int k = 1; k <= LAT; k++) begin
      tick(0, 0, 0, 0, 0, 1);
      if (k < LAT) begin
        total++; if (res_valid_o !== 1'b0) begin bad++; $display("FAIL lat_early_valid T+%0d got=%b exp=0", k, res_valid_o); end
      end
    end
    total++; if (res_valid_o !== 1'b1) begin bad++; $display("FAIL lat_valid got=%b exp=1", res_valid_o); end
    total++; if (res_o !== 32'h40A00000) begin bad++; $display("FAIL lat_res got=%h exp=40a00000", res_o); end
    total++; if (res_bypass_o !== 1'b0) begin bad++; $display("FAIL lat_bypass got=%b exp=0", res_bypass_o); end
    total++; if (res_invalid_o !== 1'b0) begin bad++; $display("FAIL lat_invalid got=%b exp=0", res_invalid_o); end
    total++; if (inflight_o !== 4'd1) begin bad++; $display("FAIL lat_inflight got=%0d exp=1", inflight_o); end
    $display("arith op: res=%h inv=%b byp=%b", res_o, res_invalid_o, res_bypass_o);
    tick(0, 0, 0, 0, 0, 1);
    total++; if (res_valid_o !== 1'b0) begin bad++; $display("FAIL lat_after_pop got=%b exp=0", res_valid_o); end
  endtask

  task automatic test_special_cases();
    case_t tc[$];
    case_t t;
    tc.push_back({32'h7F800000, 32'h00000000, 32'h3F800000, QNAN,         1'b1, 1'b1});
    tc.push_back({32'h7F800000, 32'h3F800000, 32'hFF800000, QNAN,         1'b1, 1'b1});
    tc.push_back({32'h80000000, 32'h3F800000, 32'h80000000, 32'h80000000, 1'b0, 1'b1});
    tc.push_back({32'h80000000, 32'h3F800000, 32'h00000000, 32'h00000000, 1'b0, 1'b1});
    tc.push_back({32'h7FA00000, 32'h3F800000, 32'h3F800000, QNAN,         1'b1, 1'b1});
    tc.push_back({32'h3F800000, 32'h3F800000, 32'h7FC00001, QNAN,         1'b0, 1'b1});
    tc.push_back({32'hFF800000, 32'h3F800000, 32'h40000000, 32'hFF800000, 1'b0, 1'b1});
    tc.push_back({32'h3F800000, 32'h3F800000, 32'hFF800000, 32'hFF800000, 1'b0, 1'b1});
    tc.push_back({32'h00000000, 32'h3F800000, 32'h40400000, 32'h40400000, 1'b0, 1'b1});
    tc.push_back({32'h7F800000, 32'hBF800000, 32'hFF800000, 32'hFF800000, 1'b0, 1'b1});
    tc.push_back({32'h00000000, 32'h80000000, 32'h80000000, 32'h80000000, 1'b0, 1'b1});
`ifdef FMA_SCHED_DAZ_EN
    tc.push_back({32'h00000001, 32'h7F800000, 32'h3F800000, QNAN,         1'b1, 1'b1});
    tc.push_back({32'h00000001, 32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b1});
    tc.push_back({32'h00000000, 32'h3F800000, 32'h80000001, 32'h00000000, 1'b0, 1'b1});
`else
    tc.push_back({32'h00000001, 32'h7F800000, 32'h3F800000, 32'h7F800000, 1'b0, 1'b1});
    tc.push_back({32'h00000001, 32'h3F800000, 32'h3F800000,
                  fma_mock(32'h00000001, 32'h3F800000, 32'h3F800000), 1'b0, 1'b0});
    tc.push_back({32'h00000000, 32'h3F800000, 32'h80000001, 32'h80000001, 1'b0, 1'b1});
`endif
    foreach (tc[i]) begin
      t = tc[i];
      tick(0, 1, t.a, t.b, t.c, 1);
      total++; if (mac_valid_o !== !t.byp) begin bad++; $display("FAIL sc%0d_mac_valid got=%b exp=%b", i, mac_valid_o, !t.byp); end
      for (int k = 0; k < LAT; k++) tick(0, 0, 0, 0, 0, 1);
      total++; if (res_valid_o !== 1'b1) begin bad++; $display("FAIL sc%0d_valid got=%b exp=1", i, res_valid_o); end
      total++; if (res_o !== t.res) begin bad++; $display("FAIL sc%0d_res got=%h exp=%h", i, res_o, t.res); end
      total++; if (res_invalid_o !== t.inv) begin bad++; $display("FAIL sc%0d_invalid got=%b exp=%b", i, res_invalid_o, t.inv); end
      total++; if (res_bypass_o !== t.byp) begin bad++; $display("FAIL sc%0d_bypass got=%b exp=%b", i, res_bypass_o, t.byp); end
      $display("case %0d: a=%h b=%h c=%h res=%h inv=%b byp=%b", i, t.a, t.b, t.c, res_o, res_invalid_o, res_bypass_o);
    end
    tick(0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_back_to_back();
    logic [31:0] oa [6];
    logic [31:0] ob [6];
    logic [31:0] oc [6];
    exp_t        ex [6];
    int          issued, popped, stall_cycles;
    logic        rdy, v, stall, prev_stall, prev_inv, prev_byp;
    logic [31:0] a, b, c, prev_res;
    for (int i = 0; i < 6; i++) begin
      oa[i] = rand_normal(); ob[i] = rand_normal(); oc[i] = rand_normal();
      if (i == 0) oa[i] = 32'h7F800000;
      if (i == 2) oa[i] = 32'h00000000;
      if (i == 4) ob[i] = 32'hFF800000;
      ex[i] = ref_op(oa[i], ob[i], oc[i]);
    end
    issued = 0; popped = 0; stall_cycles = 0;
    prev_stall = 1'b0; prev_res = '0; prev_inv = 1'b0; prev_byp = 1'b0;
    for (int cyc = 0; cyc < 30 && popped < 6; cyc++) begin
      rdy = !(cyc >= 4 && cyc <= 7);
      v   = (issued < 6);
      a = '0; b = '0; c = '0;
      if (v) begin a = oa[issued]; b = ob[issued]; c = oc[issued]; end
      tick(0, v, a, b, c, rdy);
      stall = res_valid_o && !rdy;
      if (stall) stall_cycles++;
      total++; if (mac_en_o !== !stall) begin bad++; $display("FAIL b2b_mac_en cyc=%0d got=%b exp=%b", cyc, mac_en_o, !stall); end
      total++; if (req_ready_o !== !stall) begin bad++; $display("FAIL b2b_req_ready cyc=%0d got=%b exp=%b", cyc, req_ready_o, !stall); end
      total++; if (inflight_o > 4'd3) begin bad++; $display("FAIL b2b_inflight cyc=%0d got=%0d exp<=3", cyc, inflight_o); end
      if (prev_stall) begin
        total++; if (res_valid_o !== 1'b1) begin bad++; $display("FAIL b2b_hold_valid cyc=%0d got=%b exp=1", cyc, res_valid_o); end
        total++; if (res_o !== prev_res) begin bad++; $display("FAIL b2b_hold_res cyc=%0d got=%h exp=%h", cyc, res_o, prev_res); end
        total++; if ({res_invalid_o, res_bypass_o} !== {prev_inv, prev_byp}) begin bad++; $display("FAIL b2b_hold_flags cyc=%0d got=%b%b exp=%b%b", cyc, res_invalid_o, res_bypass_o, prev_inv, prev_byp); end
      end
      if (res_valid_o && rdy) begin
        total++; if (popped >= 6) begin bad++; $display("FAIL b2b_extra_result cyc=%0d got=%h exp=none", cyc, res_o); end
        else begin
          if ({res_o, res_invalid_o, res_bypass_o} !== {ex[popped].res, ex[popped].inv, ex[popped].byp}) begin
            bad++; $display("FAIL b2b_result%0d got=%h/%b/%b exp=%h/%b/%b", popped, res_o, res_invalid_o, res_bypass_o, ex[popped].res, ex[popped].inv, ex[popped].byp);
          end
          $display("b2b pop %0d: res=%h inv=%b byp=%b", popped, res_o, res_invalid_o, res_bypass_o);
          popped++;
        end
      end
      if (v && req_ready_o) issued++;
      prev_stall = stall; prev_res = res_o; prev_inv = res_invalid_o; prev_byp = res_bypass_o;
    end
    total++; if (popped != 6) begin bad++; $display("FAIL b2b_count got=%0d exp=6", popped); end
    total++; if (stall_cycles != 4) begin bad++; $display("FAIL b2b_stall_cycles got=%0d exp=4", stall_cycles); end
  endtask

  task automatic test_reset_midflight();
    for (int k = 0; k < 3; k++) tick(0, 1, rand_normal(), rand_normal(), rand_normal(), 1);
    tick(1, 1, PA, PB, PC, 1);
    total++; if (inflight_o !== 4'd3) begin bad++; $display("FAIL mrst_inflight_before got=%0d exp=3", inflight_o); end
    total++; if (mac_en_o !== 1'b0) begin bad++; $display("FAIL mrst_mac_en got=%b exp=0", mac_en_o); end
    total++; if (mac_valid_o !== 1'b0) begin bad++; $display("FAIL mrst_mac_valid got=%b exp=0", mac_valid_o); end
    total++; if (req_ready_o !== 1'b0) begin bad++; $display("FAIL mrst_req_ready got=%b exp=0", req_ready_o); end
    tick(0, 0, 0, 0, 0, 1);
    total++; if (res_valid_o !== 1'b0) begin bad++; $display("FAIL mrst_res_valid got=%b exp=0", res_valid_o); end
    total++; if (inflight_o !== 4'd0) begin bad++; $display("FAIL mrst_inflight got=%0d exp=0", inflight_o); end
    total++; if ({res_o, res_invalid_o, res_bypass_o} !== 34'h0) begin bad++; $display("FAIL mrst_outputs got=%h/%b/%b exp=0/0/0", res_o, res_invalid_o, res_bypass_o); end
    tick(0, 1, PA, PB, PC, 1);
    total++; if (mac_valid_o !== 1'b1) begin bad++; $display("FAIL mrst_new_mac_valid got=%b exp=1", mac_valid_o); end
    for (int k = 1; k <= LAT; k++) begin
      tick(0, 0, 0, 0, 0, 1);
      if (k < LAT) begin
        total++; if (res_valid_o !== 1'b0) begin bad++; $display("FAIL mrst_stale_valid T+%0d got=%b exp=0", k, res_valid_o); end
      end
    end
    total++; if ({res_valid_o, res_o, res_bypass_o} !== {1'b1, 32'h40A00000, 1'b0}) begin bad++; $display("FAIL mrst_new_result got=%b/%h/%b exp=1/40a00000/0", res_valid_o, res_o, res_bypass_o); end
    $display("post-reset op: res=%h byp=%b", res_o, res_bypass_o);
    tick(0, 0, 0, 0, 0, 1);
    total++; if (inflight_o !== 4'd0) begin bad++; $display("FAIL mrst_drained got=%0d exp=0", inflight_o); end
  endtask

  task automatic test_random();
    exp_t        q[$];
    exp_t        e, h;
    logic        v, rdy, stall, acc, prev_stall, prev_inv, prev_byp;
    logic [31:0] a, b, c, prev_res;
    int          cyc;
    prev_stall = 1'b0; prev_res = '0; prev_inv = 1'b0; prev_byp = 1'b0;
    cyc = 0;
    while (cyc < 400 || (q.size() != 0 && cyc < 440)) begin
      v   = (cyc < 400) && ($urandom_range(0, 3) != 0);
      rdy = (cyc >= 400) || ($urandom_range(0, 3) != 0);
      a = rand_op(); b = rand_op(); c = rand_op();
      tick(0, v, a, b, c, rdy);
      e     = ref_op(a, b, c);
      stall = res_valid_o && !rdy;
      acc   = v && req_ready_o;
      total++; if (inflight_o !== 4'(q.size())) begin bad++; $display("FAIL rnd_inflight cyc=%0d got=%0d exp=%0d", cyc, inflight_o, q.size()); end
      total++; if (mac_en_o !== !stall) begin bad++; $display("FAIL rnd_mac_en cyc=%0d got=%b exp=%b", cyc, mac_en_o, !stall); end
      total++; if (mac_valid_o !== (acc && !e.byp)) begin bad++; $display("FAIL rnd_mac_valid cyc=%0d got=%b exp=%b", cyc, mac_valid_o, acc && !e.byp); end
      if (prev_stall) begin
        total++; if ({res_valid_o, res_o, res_invalid_o, res_bypass_o} !== {1'b1, prev_res, prev_inv, prev_byp}) begin
          bad++; $display("FAIL rnd_hold cyc=%0d got=%b/%h/%b/%b exp=1/%h/%b/%b", cyc, res_valid_o, res_o, res_invalid_o, res_bypass_o, prev_res, prev_inv, prev_byp);
        end
      end
      if (res_valid_o && rdy) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL rnd_unexpected cyc=%0d got=%h exp=none", cyc, res_o);
        end else begin
          h = q.pop_front();
          if ({res_o, res_invalid_o, res_bypass_o} !== {h.res, h.inv, h.byp}) begin
            bad++; $display("FAIL rnd_result cyc=%0d got=%h/%b/%b exp=%h/%b/%b", cyc, res_o, res_invalid_o, res_bypass_o, h.res, h.inv, h.byp);
          end
          $display("rnd pop cyc=%0d: res=%h inv=%b byp=%b", cyc, res_o, res_invalid_o, res_bypass_o);
        end
      end
      if (acc) q.push_back(e);
      prev_stall = stall; prev_res = res_o; prev_inv = res_invalid_o; prev_byp = res_bypass_o;
      cyc++;
    end
    total++; if (q.size() != 0) begin bad++; $display("FAIL rnd_drain got=%0d exp=0 pending", q.size()); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_latency();
    test_special_cases();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
